// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply / divide unit that writes its result back to a register bank.
// Define MULDIV_DIV_EN to build the restoring divider; without it OP 10/11 complete at once with no write.
module muldiv_unit #(
   parameter int WIDTH = 32,
   parameter int RADDR = 4
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             START,
   input  logic [1:0]       OP,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [RADDR-1:0] DEST,
   output logic             BUSY,
   output logic             DONE,
   output logic             DIV0,
   output logic             W_RB,
   output logic [RADDR-1:0] WC,
   output logic [WIDTH-1:0] WPC
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      WB   = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               hi_sel_q, hi_sel_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;
   logic [2*WIDTH-1:0] work_q, work_d;
   logic [RADDR-1:0]   dest_q, dest_d;
   logic [RADDR-1:0]   wc_q, wc_d;
   logic [WIDTH-1:0]   wpc_q, wpc_d;
   logic               wr_q, wr_d;
   logic               div0_q, div0_d;

   // One shared work register: {product_hi, multiplier/product_lo} or {remainder, dividend/quotient}.
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_nxt;
   logic [2*WIDTH-1:0] work_nxt;

   assign mul_sum = {1'b0, work_q[2*WIDTH-1:WIDTH]} + {1'b0, (work_q[0] ? opnd_q : '0)};
   assign mul_nxt = {mul_sum, work_q[WIDTH-1:1]};

`ifdef MULDIV_DIV_EN
   logic               is_div_q, is_div_d;
   logic [WIDTH:0]     rem_sh;
   logic               q_bit;
   logic [WIDTH-1:0]   rem_nxt;
   logic [2*WIDTH-1:0] div_nxt;

   // A zero divisor always subtracts, so the quotient fills with ones and the remainder becomes A.
   assign rem_sh   = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
   assign q_bit    = (rem_sh >= {1'b0, opnd_q});
   assign rem_nxt  = q_bit ? (rem_sh[WIDTH-1:0] - opnd_q) : rem_sh[WIDTH-1:0];
   assign div_nxt  = {rem_nxt, work_q[WIDTH-2:0], q_bit};
   assign work_nxt = is_div_q ? div_nxt : mul_nxt;
`else
   assign work_nxt = mul_nxt;
`endif

   always_comb begin
      // NOTE: every variable gets its hold value first so no path through the case infers a latch.
      state_d  = state_q;
      cnt_d    = cnt_q;
      hi_sel_d = hi_sel_q;
      opnd_d   = opnd_q;
      work_d   = work_q;
      dest_d   = dest_q;
      wc_d     = wc_q;
      wpc_d    = wpc_q;
      wr_d     = wr_q;
      div0_d   = div0_q;
`ifdef MULDIV_DIV_EN
      is_div_d = is_div_q;
`endif

      unique case (state_q)
         IDLE: begin
            if (START) begin
               hi_sel_d = OP[0];
               dest_d   = DEST;
               opnd_d   = B;
               cnt_d    = '0;
               div0_d   = 1'b0;
               if (!OP[1]) begin
                  work_d  = {{WIDTH{1'b0}}, A};
                  wr_d    = 1'b1;
                  state_d = CALC;
`ifdef MULDIV_DIV_EN
                  is_div_d = 1'b0;
`endif
               end else begin
`ifdef MULDIV_DIV_EN
                  work_d   = {{WIDTH{1'b0}}, A};
                  wr_d     = 1'b1;
                  div0_d   = (B == '0);
                  is_div_d = 1'b1;
                  state_d  = CALC;
`else
                  wr_d     = 1'b0;
                  wpc_d    = '0;
                  state_d  = WB;
`endif
               end
            end
         end

         CALC: begin
            work_d = work_nxt;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = WB;
               wc_d    = dest_q;
               wpc_d   = hi_sel_q ? work_nxt[2*WIDTH-1:WIDTH] : work_nxt[WIDTH-1:0];
            end
         end

         WB:      state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         hi_sel_q <= 1'b0;
         opnd_q   <= '0;
         work_q   <= '0;
         dest_q   <= '0;
         wc_q     <= '0;
         wpc_q    <= '0;
         wr_q     <= 1'b0;
         div0_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         hi_sel_q <= hi_sel_d;
         opnd_q   <= opnd_d;
         work_q   <= work_d;
         dest_q   <= dest_d;
         wc_q     <= wc_d;
         wpc_q    <= wpc_d;
         wr_q     <= wr_d;
         div0_q   <= div0_d;
      end
   end

`ifdef MULDIV_DIV_EN
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) is_div_q <= 1'b0;
      else       is_div_q <= is_div_d;
   end
`endif

   // Strobes are qualified by WB so they drop the instant reset forces IDLE.
   assign BUSY = (state_q != IDLE);
   assign DONE = (state_q == WB);
   assign W_RB = (state_q == WB) && wr_q;
   assign DIV0 = (state_q == WB) && div0_q;
   assign WC   = wc_q;
   assign WPC  = wpc_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized self-checking bench for muldiv_unit against an arithmetic reference model.
// Follows the MULDIV_DIV_EN setting of the build for the divide-path expectations.
module tb_muldiv_unit;

   localparam int W  = 32;
   localparam int RA = 4;

   logic          CLK = 1'b0;
   logic          RESET;
   logic          START;
   logic [1:0]    OP;
   logic [W-1:0]  A, B;
   logic [RA-1:0] DEST;
   logic          BUSY, DONE, DIV0, W_RB;
   logic [RA-1:0] WC;
   logic [W-1:0]  WPC;

   int checks = 0;
   int errors = 0;

   logic [RA-1:0] exp_wc  = '0;
   logic [W-1:0]  exp_wpc = '0;

   muldiv_unit #(.WIDTH(W), .RADDR(RA)) dut (
      .CLK(CLK), .RESET(RESET), .START(START), .OP(OP), .A(A), .B(B), .DEST(DEST),
      .BUSY(BUSY), .DONE(DONE), .DIV0(DIV0), .W_RB(W_RB), .WC(WC), .WPC(WPC)
   );

   always #5 CLK = ~CLK;

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

`ifdef MULDIV_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif

   // Reference result from plain arithmetic on 64-bit unsigned values.
   function automatic logic [W-1:0] ref_result(input logic [1:0] op, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
      longint unsigned p;
      p = longint'(a) * longint'(b);
      case (op)
         2'd0:    return p[W-1:0];
         2'd1:    return p[2*W-1:W];
         2'd2:    return (b == 0) ? '1 : a / b;
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   task automatic scramble_inputs();
      OP   = 2'($urandom);
      A    = $urandom;
      B    = $urandom;
      DEST = RA'($urandom);
   endtask

   // Issue one command; optionally re-pulse START at CALC cycle inject_at and/or during WB.
   task automatic run_cmd(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [RA-1:0] dest, input int inject_at, input bit start_in_wb);
      logic [W-1:0] exp_res;
      bit           exp_wr, exp_div0, seen, stray;
      int           exp_lat, n;

      if (op[1] && !DIV_EN) begin
         exp_res = '0; exp_wr = 1'b0; exp_div0 = 1'b0; exp_lat = 0;
      end else begin
         exp_res  = ref_result(op, a, b);
         exp_wr   = 1'b1;
         exp_div0 = op[1] && (b == 0);
         exp_lat  = W;
      end

      START = 1'b1; OP = op; A = a; B = b; DEST = dest;
      @(posedge CLK); #1;
      START = 1'b0;
      scramble_inputs();
      check("busy_start", 64'(BUSY), 64'd1);

      n = 0; seen = 1'b0; stray = 1'b0;
      while (!seen && n < 3 * W) begin
         if (DONE) seen = 1'b1;
         else begin
            if (W_RB) stray = 1'b1;
            if (inject_at > 0 && n == inject_at) begin
               START = 1'b1;
               scramble_inputs();
            end
            @(posedge CLK); #1;
            START = 1'b0;
            n++;
         end
      end

      check("done_seen", 64'(seen), 64'd1);
      check("latency", 64'(n), 64'(exp_lat));
      check("no_early_wr", 64'(stray), 64'd0);
      check("w_rb", 64'(W_RB), 64'(exp_wr));
      check("wpc", 64'(WPC), 64'(exp_res));
      check("div0", 64'(DIV0), 64'(exp_div0));
      if (exp_wr) begin
         check("wc", 64'(WC), 64'(dest));
         exp_wc = dest;
      end
      exp_wpc = exp_res;

      if (start_in_wb) begin
         START = 1'b1;
         scramble_inputs();
      end
      @(posedge CLK); #1;
      START = 1'b0;
      check("done_drop", 64'(DONE), 64'd0);
      check("busy_drop", 64'(BUSY), 64'd0);
      check("wc_hold", 64'(WC), 64'(exp_wc));
      check("wpc_hold", 64'(WPC), 64'(exp_wpc));
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, 64'(BUSY), 64'd0);
      check({tag, "_done"}, 64'(DONE), 64'd0);
      check({tag, "_div0"}, 64'(DIV0), 64'd0);
      check({tag, "_w_rb"}, 64'(W_RB), 64'd0);
      check({tag, "_wc"},   64'(WC),   64'd0);
      check({tag, "_wpc"},  64'(WPC),  64'd0);
   endtask

   task automatic reset_mid_calc();
      bit stray;
      START = 1'b1; OP = 2'd0; A = 32'h1234_5678; B = 32'h0000_0FFF; DEST = 4'd9;
      @(posedge CLK); #1;
      START = 1'b0;
      repeat (15) @(posedge CLK);
      #1;
      RESET = 1'b1;
      #1;
      check_all_zero("abort");
      exp_wc = '0; exp_wpc = '0;
      repeat (2) @(posedge CLK);
      #1;
      RESET = 1'b0;
      stray = 1'b0;
      for (int i = 0; i < W + 8; i++) begin
         @(posedge CLK); #1;
         if (W_RB || DONE || BUSY) stray = 1'b1;
      end
      check("abort_quiet", 64'(stray), 64'd0);
   endtask

   initial begin
      RESET = 1'b1; START = 1'b0; OP = '0; A = '0; B = '0; DEST = '0;
      #1;
      check_all_zero("reset");
      repeat (2) @(posedge CLK);
      #1;
      RESET = 1'b0;
      @(posedge CLK); #1;

      run_cmd(2'd0, 32'h0000_0007, 32'h0000_0006, 4'd3, 0, 1'b0);
      run_cmd(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd5, 0, 1'b0);
      run_cmd(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd5, 0, 1'b0);
      run_cmd(2'd2, 32'd100, 32'd7, 4'd1, 0, 1'b0);
      run_cmd(2'd3, 32'd100, 32'd7, 4'd2, 0, 1'b0);
      run_cmd(2'd2, 32'h0000_1234, 32'd0, 4'd4, 0, 1'b0);
      run_cmd(2'd3, 32'h0000_1234, 32'd0, 4'd6, 0, 1'b0);
      run_cmd(2'd0, 32'd3, 32'd4, 4'd7, 0, 1'b0);
      run_cmd(2'd0, 32'h0001_0003, 32'h0000_0011, 4'd8, 10, 1'b0);
      run_cmd(2'd1, 32'h8000_0001, 32'h0000_0003, 4'd10, 0, 1'b1);
      run_cmd(2'd2, 32'd100, 32'd7, 4'd11, 0, 1'b1);
      reset_mid_calc();
      run_cmd(2'd0, 32'd3, 32'd4, 4'd12, 0, 1'b0);

      for (int k = 0; k < 40; k++) begin
         logic [W-1:0] ra, rb;
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 3))
            0: rb = 32'd0;
            1: rb = rb >> $urandom_range(0, 31);
            2: ra = ra >> $urandom_range(0, 31);
            default: ;
         endcase
         run_cmd(2'($urandom), ra, rb, RA'($urandom), (k % 5 == 0) ? int'($urandom_range(1, 30)) : 0,
                 1'(k % 3 == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL take parameter WIDTH, default 32, as the operand/result width matching the register bank data path.
REQ-002 The block SHALL take parameter RADDR, default 4, as the register address width matching WC of the register bank.
REQ-003 CLK  input  1  sole clock, all state updates on rising edge.
REQ-004 RESET  input  1  asynchronous, active-high reset.
REQ-005 START  input  1  command strobe, sampled only in IDLE.
REQ-006 OP  input  2  operation: 00 MUL low word, 01 MUL high word, 10 DIVU quotient, 11 DIVU remainder (all unsigned).
REQ-007 A  input  WIDTH  operand A, driven from register bank PRA.
REQ-008 B  input  WIDTH  operand B, driven from register bank PRB.
REQ-009 DEST  input  RADDR  destination register index for the result.
REQ-010 BUSY  output  1  high while a command is in progress (CALC or WB).
REQ-011 DONE  output  1  one-cycle completion pulse.
REQ-012 DIV0  output  1  divide-by-zero flag, valid only while DONE is high.
REQ-013 W_RB  output  1  write-enable to register bank.
REQ-014 WC  output  RADDR  write address to register bank.
REQ-015 WPC  output  WIDTH  write data to register bank.

Function
REQ-016 The FSM SHALL have states IDLE, CALC, WB.
REQ-017 In IDLE, START=1 SHALL latch OP, A, B, DEST, clear the iteration counter, and enter CALC at that edge.
REQ-018 CALC SHALL perform one iteration per cycle for exactly WIDTH cycles, then enter WB.
REQ-019 Multiply SHALL be radix-2 shift-add producing a 2*WIDTH product; OP 00 returns product[WIDTH-1:0], OP 01 returns product[2*WIDTH-1:WIDTH].
REQ-020 Divide SHALL be restoring radix-2 producing WIDTH-bit quotient and remainder.
REQ-021 Divide with B=0 SHALL return quotient all-ones and remainder A, and assert DIV0 with DONE.
REQ-022 WB SHALL last one cycle with DONE=1, W_RB=1, WC=latched DEST, WPC=selected result, then return to IDLE.
REQ-023 DONE SHALL go high on the cycle after the WIDTH-th edge following the START-sampling edge (32 cycles for WIDTH=32).
REQ-024 W_RB, DONE, DIV0 SHALL be low in all states except WB; WC and WPC SHALL hold their last value outside WB.
REQ-025 START while BUSY=1 SHALL be ignored with no queuing.
REQ-026 START in the WB cycle SHALL be ignored; a new command is accepted from IDLE only.
REQ-027 A, B, DEST, OP changes after the START-sampling edge SHALL not affect the in-flight result.

Reset
REQ-028 RESET=1 SHALL immediately force state IDLE, counter 0, BUSY=0, DONE=0, DIV0=0, W_RB=0, WC=0, WPC=0.
REQ-029 RESET asserted during CALC or WB SHALL abort the command with no register write issued.

Configuration
REQ-030 Macro MULDIV_DIV_EN defined: divider datapath SHALL be compiled in and behave per REQ-020/021.
REQ-031 Macro MULDIV_DIV_EN undefined: divider SHALL be absent; OP 10/11 SHALL go IDLE -> WB directly with DONE=1, W_RB=0, WPC=0, DIV0=0 (no register write); multiply is unaffected.

Verification
REQ-032 OP=00, A=0x0000_0007, B=0x0000_0006, DEST=3 -> DONE 32 cycles later, W_RB=1, WC=3, WPC=0x0000_002A, DIV0=0.
REQ-033 OP=01, A=0xFFFF_FFFF, B=0xFFFF_FFFF, DEST=5 -> WPC=0xFFFF_FFFE, WC=5; repeat with OP=00 -> WPC=0x0000_0001.
REQ-034 MULDIV_DIV_EN defined: OP=10 A=100 B=7 -> WPC=14; OP=11 same operands -> WPC=2; OP=10 B=0 A=0x1234 -> WPC=0xFFFF_FFFF, DIV0=1; OP=11 B=0 -> WPC=0x1234.
REQ-035 START pulsed again at cycle 10 of a MUL with different A/B/DEST -> ignored, single DONE, original result and WC.
REQ-036 RESET asserted at cycle 15 of CALC -> all outputs 0 within the same cycle, no W_RB pulse, next START accepted normally.
REQ-037 MULDIV_DIV_EN undefined: OP=10 A=100 B=7 -> DONE on the next cycle, W_RB=0, WPC=0; then OP=00 A=3 B=4 -> WPC=12.
